// File: rtl/pe_pkg.sv
// +--------------------------------------------------------------------+
// | pe_pkg : shared width and word type for the pe_mac compute cell     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package pe_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] pe_word_t;

endpackage : pe_pkg

`default_nettype wire

// File: rtl/pe_mul.sv
// +--------------------------------------------------------------------+
// | pe_mul : combinational unsigned DATA_W x DATA_W full-width multiply |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pe_mul
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W
) (
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [2*DATA_W-1:0] o_p
);

  assign o_p = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

endmodule : pe_mul

`default_nettype wire

// File: rtl/pe_mac.sv
// +--------------------------------------------------------------------+
// | pe_mac : one unsigned multiply-accumulate per clock, wrapping acc   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c
);

  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_prod_lo;
  logic                w_unused_prod_hi;
  logic [DATA_W-1:0]   r_acc;

  pe_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .i_a (a),
    .i_b (b),
    .o_p (w_prod)
  );

  // Only the low half feeds the wrapping accumulator; upper bits are dropped.
  assign w_prod_lo        = w_prod[DATA_W-1:0];
  assign w_unused_prod_hi = ^w_prod[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= r_acc + w_prod_lo;
    end
  end

  assign c = r_acc;

endmodule : pe_mac

`default_nettype wire

// File: tb/tb_pe_mac.sv
// +--------------------------------------------------------------------+
// | tb_pe_mac : scoreboard bench for pe_mac (directed + random vectors) |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pe_mac;
  import pe_pkg::*;

  logic     clk;
  logic     rst;
  pe_word_t a;
  pe_word_t b;
  pe_word_t c;

  int       n_vec;
  int       n_err;
  pe_word_t r_model;
  pe_word_t q_exp[$];
  string    q_tag[$];

  pe_mac #(
    .DATA_W (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input pe_word_t obs, input pe_word_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: c=0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, push the expectation, check right after the rising edge.
  // A literal expectation is used when use_lit is set; otherwise the reference model.
  task automatic step(input string tag, input logic r, input pe_word_t va, input pe_word_t vb,
                      input bit use_lit, input pe_word_t lit);
    logic [2*DATA_W-1:0] prod;
    string               t;
    pe_word_t            e;
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    prod = 64'(va) * 64'(vb);
    if (r) r_model = '0;
    else   r_model = r_model + prod[DATA_W-1:0];
    q_exp.push_back(use_lit ? lit : r_model);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    chk(t, c, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    r_model = '0;
    rst = 1'b1;
    a   = '0;
    b   = '0;

    // Reset and idle
    step("reset",      1'b1, 32'h0, 32'h0, 1'b1, 32'h0);
    step("rst_hold",   1'b1, 32'h5, 32'h5, 1'b1, 32'h0);
    step("idle_zero",  1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Basic MAC
    step("mac1",       1'b0, 32'h1, 32'h1, 1'b1, 32'h1);
    step("mac2",       1'b0, 32'h2, 32'h2, 1'b1, 32'h5);
    step("mac3",       1'b0, 32'h3, 32'h3, 1'b1, 32'hE);

    // Wrap modulo 2^32
    step("to_fffffffe", 1'b0, 32'hFFFF_FFF0, 32'h1, 1'b1, 32'hFFFF_FFFE);
    step("wrap",        1'b0, 32'h3,         32'h1, 1'b1, 32'h1);

    // Product truncation
    step("trunc_rst",  1'b1, 32'h0,         32'h0,         1'b1, 32'h0);
    step("trunc_set5", 1'b0, 32'h5,         32'h1,         1'b1, 32'h5);
    step("trunc_2p32", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h5);
    step("trunc_part", 1'b0, 32'h0001_0001, 32'h0001_0000, 1'b1, 32'h0001_0005);

    // Reset priority over accumulate
    step("prio_rst",   1'b1, 32'h0, 32'h0, 1'b1, 32'h0);
    step("prio_set14", 1'b0, 32'hE, 32'h1, 1'b1, 32'hE);
    step("prio_hit",   1'b1, 32'h7, 32'h7, 1'b1, 32'h0);
    step("prio_after", 1'b0, 32'h2, 32'h2, 1'b1, 32'h4);

    // Zero operand holds the accumulator
    step("zero_set9",  1'b0, 32'h5, 32'h1, 1'b1, 32'h9);
    for (int i = 0; i < 3; i++)
      step("zero_hold", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h9);

    // Random operands with occasional reset, checked against the model
    for (int i = 0; i < 40; i++)
      step("random", ($urandom_range(0, 15) == 0), $urandom, $urandom, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pe_mac

`default_nettype wire
